// File: rtl/sharpen_filter_3x3.sv
// Streaming 3x3 Laplacian sharpen for one raster-ordered channel. Output k is
// produced when input k+IMG_W+1 arrives, or during the IMG_W+1 cycle flush at frame end.
module sharpen_filter_3x3 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  input  logic             frame_start,
  output logic             data_in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_done,
  output logic             frame_done
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int IW    = $clog2(N);
  localparam int SW    = WIDTH + 4;
  localparam int BUF_D = 2 * IMG_W + 1;

  localparam logic [CW-1:0]        COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_H - 1);
  localparam logic [IW-1:0]        IDX_LAST = IW'(N - 1);
  localparam logic signed [SW-1:0] PIX_MAX  = SW'((1 << WIDTH) - 1);

  // Handshake: a pixel transfers on a cycle where data_in_valid && data_in_ready;
  // upstream holds data_in/frame_start stable while data_in_ready is low.
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t r_state, w_next_state;

  logic [CW-1:0] r_in_col, r_out_col;
  logic [RW-1:0] r_in_row, r_out_row;
  logic [IW-1:0] r_out_idx;
  logic [WIDTH-1:0] r_buf [BUF_D];

  logic r_s1_valid, r_s1_border, r_s1_last;
  logic signed [SW-1:0] r_s1_sum;
  logic [WIDTH-1:0] r_s1_centre;

  logic w_accept, w_start, w_produce, w_shift;
  logic w_in_fill_end, w_in_last, w_border;
  logic signed [SW-1:0] w_c, w_n, w_s, w_e, w_w, w_sum;
  logic [WIDTH-1:0] w_clamped;

  assign data_in_ready = !reset && (r_state != S_FLUSH);
  assign w_accept      = data_in_valid && data_in_ready;
  assign w_start       = w_accept && frame_start;
  assign w_shift       = w_accept || (r_state == S_FLUSH);

  // Input counters hold the position of the next pixel expected.
  assign w_in_fill_end = (r_in_row == RW'(1)) && (r_in_col == '0);
  assign w_in_last     = (r_in_row == ROW_LAST) && (r_in_col == COL_LAST);

  always_comb begin
    w_next_state = r_state;
    w_produce    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_FILL;
      end
      S_FILL: begin
        if (w_start) w_next_state = S_FILL;
        else if (w_accept && w_in_fill_end) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_start) begin
          w_next_state = S_FILL;
        end else if (w_accept) begin
          w_produce = 1'b1;
          if (w_in_last) w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_produce = 1'b1;
        if (r_out_idx == IDX_LAST) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_col <= '0;
      r_in_row <= '0;
    end else if (w_start) begin
      r_in_col <= CW'(1);
      r_in_row <= '0;
    end else if (w_accept && r_state != S_IDLE) begin
      if (r_in_col == COL_LAST) begin
        r_in_col <= '0;
        r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + RW'(1);
      end else begin
        r_in_col <= r_in_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_out_col <= '0;
      r_out_row <= '0;
      r_out_idx <= '0;
    end else if (w_produce) begin
      r_out_idx <= (r_out_idx == IDX_LAST) ? '0 : r_out_idx + IW'(1);
      if (r_out_col == COL_LAST) begin
        r_out_col <= '0;
        r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + RW'(1);
      end else begin
        r_out_col <= r_out_col + CW'(1);
      end
    end
  end

  // r_buf[i] holds the pixel accepted i+1 steps ago; flush steps shift in filler.
  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_buf[0] <= w_accept ? data_in : '0;
      for (int i = 1; i < BUF_D; i++) r_buf[i] <= r_buf[i-1];
    end
  end

  assign w_s   = $signed({4'b0, r_buf[0]});
  assign w_e   = $signed({4'b0, r_buf[IMG_W-1]});
  assign w_c   = $signed({4'b0, r_buf[IMG_W]});
  assign w_w   = $signed({4'b0, r_buf[IMG_W+1]});
  assign w_n   = $signed({4'b0, r_buf[2*IMG_W]});
  assign w_sum = (w_c <<< 2) + w_c - w_n - w_s - w_e - w_w;

  assign w_border = (r_out_row == '0) || (r_out_row == ROW_LAST) ||
                    (r_out_col == '0) || (r_out_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_border <= 1'b0;
      r_s1_centre <= '0;
      r_s1_last   <= 1'b0;
    end else begin
      r_s1_valid <= w_produce;
      if (w_produce) begin
        r_s1_sum    <= w_sum;
        r_s1_border <= w_border;
        r_s1_centre <= r_buf[IMG_W];
        r_s1_last   <= (r_out_idx == IDX_LAST);
      end
    end
  end

  always_comb begin
    w_clamped = r_s1_sum[WIDTH-1:0];
    if (r_s1_border)            w_clamped = r_s1_centre;
    else if (r_s1_sum[SW-1])    w_clamped = '0;
    else if (r_s1_sum > PIX_MAX) w_clamped = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out      <= '0;
      data_out_done <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      data_out_done <= r_s1_valid;
      frame_done    <= r_s1_valid && r_s1_last;
      if (r_s1_valid) data_out <= w_clamped;
    end
  end

endmodule

// File: tb/tb_sharpen_filter_3x3.sv
// Bench for sharpen_filter_3x3 on a 4x4 frame: a 2-D reference model fills the
// expected queue, one negedge monitor checks every strobe against it.
module tb_sharpen_filter_3x3;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int N     = IMG_W * IMG_H;

  typedef logic [WIDTH-1:0] frame_t [N];

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_in_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             data_in_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_out_done;
  logic             frame_done;

  sharpen_filter_3x3 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .frame_start   (frame_start),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_done (data_out_done),
    .frame_done    (frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [WIDTH-1:0] got_q[$];
  int compared = 0;
  int mismatched = 0;
  int n_done = 0;
  int first_done_cyc = -1;
  int last_acc_cyc = 0;
  logic ev_p1 = 1'b0, ev_p2 = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: border pixels pass through, interior is 5C-N-S-E-W clamped to 0..255.
  function automatic logic [WIDTH-1:0] model_px(input frame_t f, input int k);
    int r, c, s;
    r = k / IMG_W;
    c = k % IMG_W;
    if (r == 0 || r == IMG_H-1 || c == 0 || c == IMG_W-1) return f[k];
    s = 5 * int'(f[k]) - int'(f[k-IMG_W]) - int'(f[k+IMG_W]) - int'(f[k-1]) - int'(f[k+1]);
    if (s < 0) return '0;
    if (s > 255) return 8'd255;
    return WIDTH'(s);
  endfunction

  task automatic push_expected(input frame_t f, input int count, input bit complete);
    for (int k = 0; k < count; k++) begin
      exp_q.push_back(model_px(f, k));
      exp_last_q.push_back(complete && (k == N-1));
    end
  endtask

  // ---------------- monitor / compare ----------------
  always @(negedge clk) begin
    logic ev_now;
    logic [WIDTH-1:0] e;
    logic el;
    ev_now = (data_in_valid && data_in_ready) || (!data_in_ready && !reset);
    if (data_out_done === 1'b1) begin
      n_done++;
      if (got_q.size() == 0) first_done_cyc = cyc;
      got_q.push_back(data_out);
      compared++;
      if (ev_p2 !== 1'b1) begin
        mismatched++;
        $display("FAIL strobe_timing: strobe at cycle %0d, expected accept or flush step at cycle %0d", cyc, cyc-2);
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe: data_out=%0d at cycle %0d, expected no strobe", data_out, cyc);
      end else begin
        e  = exp_q.pop_front();
        el = exp_last_q.pop_front();
        if (data_out !== e || frame_done !== el) begin
          mismatched++;
          $display("FAIL stream_out: got data_out=%0d frame_done=%0b, expected %0d/%0b (cycle %0d)",
                   data_out, frame_done, e, el, cyc);
        end
      end
    end else if (frame_done === 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL stray_frame_done: frame_done=1 with data_out_done=0, expected 0 (cycle %0d)", cyc);
    end
    ev_p2 = ev_p1;
    ev_p1 = ev_now;
  end

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [WIDTH-1:0] v, input logic fs, input int gap_pct);
    logic acc;
    acc = 1'b0;
    for (int g = 0; g < 4 && gap_pct > 0 && $urandom_range(99, 0) < gap_pct; g++) begin
      data_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    data_in = v;
    frame_start = fs;
    data_in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      acc = data_in_ready;
      if (acc) last_acc_cyc = cyc;
      @(posedge clk); #1;
      if (acc) break;
    end
    compared++;
    if (!acc) begin
      mismatched++;
      $display("FAIL accept_timeout: ready=0 for 40 cycles, expected acceptance");
    end
    data_in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input frame_t f, input int gap_pct);
    int acc_out0, fl;
    acc_out0 = 0;
    got_q.delete();
    first_done_cyc = -1;
    push_expected(f, N, 1'b1);
    for (int k = 0; k < N; k++) begin
      send_pixel(f[k], k == 0, gap_pct);
      if (k == IMG_W + 1) acc_out0 = last_acc_cyc;
    end
    fl = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (data_in_ready) break;
      fl++;
    end
    check("flush_ready_low_cycles", fl, IMG_W + 1);
    repeat (10) @(posedge clk);
    #1;
    check("frame_strobe_count", got_q.size(), N);
    check("frame_queue_drained", exp_q.size(), 0);
    // Output 0 is born from input index IMG_W+1 and appears two cycles later.
    if (gap_pct == 0) check("first_output_latency", first_done_cyc - acc_out0, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    frame_t f1, f2, f3, f4, fa, fb;
    int nd;
    for (int k = 0; k < N; k++) begin
      f1[k] = 8'd100;
      f2[k] = 8'd0;
      f3[k] = 8'd10;
      f4[k] = 8'd77;
      fa[k] = WIDTH'(k * 15 + 5);
      fb[k] = WIDTH'((k * 37 + 11) % 256);
    end
    f2[5] = 8'd200;
    f3[5] = 8'd50;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", data_out, 0);
    check("reset_done", data_out_done, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_ready", data_in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", data_in_ready, 1);
    @(posedge clk); #1;

    // Flat frame: everything passes through unchanged.
    run_frame(f1, 0);
    check("flat_out_1_1", got_q[5], 100);

    // Single bright pixel.
    run_frame(f2, 0);
    check("spike_out_1_1", got_q[5], 255);
    check("spike_out_1_2", got_q[6], 0);
    check("spike_out_2_1", got_q[9], 0);
    check("spike_out_2_2", got_q[10], 0);
    check("spike_out_0_1", got_q[1], 0);

    run_frame(f3, 0);
    check("bump_out_1_1", got_q[5], 210);
    check("bump_out_2_2", got_q[10], 10);
    check("bump_out_1_2", got_q[6], 0);

    // Pixels without frame_start in IDLE are dropped.
    nd = n_done;
    for (int i = 0; i < 6; i++) send_pixel(WIDTH'(i * 7 + 1), 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("idle_drop_strobes", n_done - nd, 0);

    // Same frame with random valid gaps.
    run_frame(f3, 50);
    check("gap_bump_out_1_1", got_q[5], 210);
    check("gap_bump_out_2_2", got_q[10], 10);

    // Reset after 7 accepts: output 0 is already in the last stage, output 1 is lost.
    exp_q.push_back(8'd30);
    exp_last_q.push_back(1'b0);
    for (int k = 0; k < 7; k++) send_pixel(WIDTH'(30 + k), k == 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("done_after_mid_reset", data_out_done, 0);
    check("ready_after_mid_reset", data_in_ready, 1);
    @(posedge clk); #1;
    run_frame(f4, 0);
    check("val77_out_1_1", got_q[5], 77);

    // Restart mid-RUN: outputs 0..3 of frame A are in flight and still emit.
    push_expected(fa, 4, 1'b0);
    for (int k = 0; k < 9; k++) send_pixel(fa[k], k == 0, 0);
    repeat (4) @(posedge clk);
    #1;
    run_frame(fb, 0);

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
